// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction per cycle, waits for load
// responses, extends load data and drives the register-file write port.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             regwen_i,
  input  logic [RA_W-1:0]  rd_i,
  input  logic [1:0]       wbsel_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  alu_i,
  input  logic [XLEN-1:0]  pc4_i,
  input  logic             dmem_rvalid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             RegWEn_o,
  output logic [RA_W-1:0]  AddrD_o,
  output logic [XLEN-1:0]  DataD_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_e;

  state_e            state_q, state_d;
  logic              regwen_q, regwen_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              wen_q, wen_d;
  logic [RA_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [CNT_W-1:0]  instret_q;
  logic              xfer;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  assign ready_o   = (state_q != WAIT_MEM);
  assign busy_o    = (state_q == WAIT_MEM);
  assign xfer      = valid_i & ready_o;
  assign RegWEn_o  = wen_q;
  assign AddrD_o   = addr_q;
  assign DataD_o   = data_q;
  assign instret_o = instret_q;

  // Lane selection uses the offset captured with the load, not the live alu_i.
  assign ld_byte = dmem_rdata_i[8*off_q +: 8];
  assign ld_half = dmem_rdata_i[16*off_q[1] +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    regwen_d = regwen_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    wen_d    = 1'b0;
    addr_d   = '0;
    data_d   = '0;
    case (state_q)
      IDLE, COMMIT: begin
        if (xfer) begin
          regwen_d = regwen_i;
          rd_d     = rd_i;
          funct3_d = funct3_i;
          off_d    = alu_i[1:0];
          if (wbsel_i == 2'b01) begin
            state_d = WAIT_MEM;
          end else begin
            state_d = COMMIT;
            wen_d   = regwen_i;
            addr_d  = rd_i;
            data_d  = (wbsel_i == 2'b10) ? pc4_i : alu_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (dmem_rvalid_i) begin
          state_d = COMMIT;
          wen_d   = regwen_q;
          addr_d  = rd_q;
          data_d  = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port outputs are loaded on entry to COMMIT so they come straight from flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      regwen_q  <= 1'b0;
      rd_q      <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      regwen_q <= regwen_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      if (state_d == COMMIT) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the ares-riscv pipeline, directly upstream of the 32x32 register file.
- Accepts one retiring instruction per cycle from the memory stage and waits, with variable latency, for data-memory load responses.
- Aligns and sign- or zero-extends load data, selects the writeback source, and drives the register-file write port (write enable, destination address, write data) for exactly one cycle per instruction.
- Also maintains a retired-instruction counter.

Parameters:
XLEN, 32, data width of results and register-file write data
RA_W, 5, register address width
CNT_W, 64, width of retired-instruction counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
valid_i  in  1  memory stage presents an instruction
ready_o  out  1  stage can accept an instruction this cycle
regwen_i  in  1  instruction writes a register
rd_i  in  RA_W  destination register
wbsel_i  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as ALU)
funct3_i  in  3  load type
alu_i  in  XLEN  ALU result; also the load address (bits [1:0] are the byte offset)
pc4_i  in  XLEN  PC+4
dmem_rvalid_i  in  1  load response valid
dmem_rdata_i  in  XLEN  load response word (naturally aligned)
RegWEn_o  out  1  register-file write enable
AddrD_o  out  RA_W  register-file write address
DataD_o  out  XLEN  register-file write data
busy_o  out  1  high in WAIT_MEM
instret_o  out  CNT_W  count of committed instructions

Behaviour:
- Reset is asynchronous and active-high, on one clock (clk_i).
  - state = IDLE; all captured fields cleared.
  - RegWEn_o = 0, AddrD_o = 0, DataD_o = 0.
  - instret_o = 0, busy_o = 0, ready_o = 1 (combinational from state).
  - Asserting rst_i mid-load abandons the load; a later dmem_rvalid_i in IDLE is ignored.
- States: IDLE, WAIT_MEM, COMMIT.
- ready_o = 1 in IDLE and COMMIT; 0 in WAIT_MEM. Transfer = valid_i & ready_o.
- On transfer:
  - Capture regwen_i, rd_i, wbsel_i, funct3_i, alu_i[1:0], and the selected result (alu_i or pc4_i).
  - wbsel_i == 01 -> WAIT_MEM; otherwise -> COMMIT.
- IDLE with no transfer: stays in IDLE.
- WAIT_MEM:
  - dmem_rvalid_i = 1: extended load data is registered as the result, -> COMMIT.
  - Otherwise hold indefinitely (no timeout).
- COMMIT (exactly one cycle per instruction):
  - RegWEn_o = captured regwen; AddrD_o = captured rd; DataD_o = captured result.
  - instret_o increments by 1, wrapping modulo 2^CNT_W.
  - Transfer in the same cycle -> COMMIT or WAIT_MEM per the new wbsel; no transfer -> IDLE.
  - Back-to-back non-load instructions therefore commit on consecutive cycles (throughput 1/cycle, latency 1 cycle from transfer to write).
- Outside COMMIT: RegWEn_o = 0, AddrD_o = 0, DataD_o = 0. All three outputs are registered and glitch-free.
- rd = 0 with regwen = 1 is still driven (RegWEn_o = 1, AddrD_o = 0); the register file discards it. The commit still counts toward instret_o.
- Load extraction, with off = captured alu[1:0]:
  - 000 LB: byte rdata[8*off+7 : 8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half rdata[16*off[1]+15 : 16*off[1]], sign-extended; off[0] ignored (misalignment is trapped upstream).
  - 101 LHU: same half, zero-extended.
  - 010 LW and all other codes: full word; offset ignored.
- dmem_rvalid_i in IDLE or COMMIT: ignored.
- A load response and a new instruction cannot coincide, since ready_o = 0 in WAIT_MEM.
- valid_i while ready_o = 0: the memory stage must hold its inputs stable until transfer.

Test Plan:
- Reset released; valid_i=1, wbsel=00, rd=5, regwen=1, alu=0x0000_1234 -> next cycle RegWEn_o=1, AddrD_o=5, DataD_o=0x1234, instret_o=1; following cycle RegWEn_o=0.
- Three back-to-back ALU ops to rd=1,2,3 with data 0xA,0xB,0xC, plus one JAL (wbsel=10, pc4=0x104, rd=1) -> four consecutive commit cycles with those values; ready_o stays 1; instret_o=4.
- LB with alu=0x...3, rdata arriving 3 cycles later = 0x8012_3456 -> ready_o=0 and busy_o=1 while waiting; commit DataD_o=0xFFFF_FF80. Same stimulus with LBU -> 0x0000_0080.
- LH with off=2, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW off=0 -> 0x8001_7FFF.
- Load issued; rst_i pulsed while in WAIT_MEM, then dmem_rvalid_i=1 -> no write occurs; instret_o=0; ready_o=1.
- Commit to rd=0 with regwen=1 -> RegWEn_o=1, AddrD_o=0; instret increments. Instruction with regwen=0 -> RegWEn_o=0 in its commit cycle; instret increments.
